// File: rtl/speed_ctrl_multi.sv
// Multi-channel playback-period controller with saturating steps
// and press-and-hold auto-repeat on the selected channel.
module speed_ctrl_multi #(
  parameter int WIDTH         = 32,
  parameter int CHANNELS      = 2,
  parameter int DEFAULT       = 1227,
  parameter int STEP          = 4,
  parameter int MIN_VAL       = 256,
  parameter int MAX_VAL       = 4096,
  parameter int HOLD_CYCLES   = 12_500_000,
  parameter int REPEAT_CYCLES = 2_500_000,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      speed_up,
  input  logic                      speed_down,
  input  logic                      speed_rst,
  input  logic [CW-1:0]             ch_sel,
  output logic [CHANNELS*WIDTH-1:0] count_out,
  output logic                      at_min,
  output logic                      at_max,
  output logic                      step_pulse
);

  localparam int CMAX =
    (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CTW = $clog2(CMAX + 1);

  localparam logic [WIDTH:0] MIN_X  = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0] MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0] STEP_X = (WIDTH+1)'(STEP);
  localparam logic [WIDTH:0] DEF_X  = (WIDTH+1)'(DEFAULT);
  localparam logic [WIDTH-1:0] DEF_V = WIDTH'(DEFAULT);
  localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);

  localparam logic [CTW-1:0] HOLD_END = CTW'(HOLD_CYCLES - 1);
  localparam logic [CTW-1:0] REP_END  = CTW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_REPEAT
  } state_t;

  typedef enum logic [1:0] {
    C_NONE,
    C_UP,
    C_DN,
    C_RST
  } cmd_t;

  logic [WIDTH-1:0] vals [CHANNELS];

  state_t         state, state_n;
  logic           dir, dir_n;
  logic [CW-1:0]  lch, lch_n;
  logic [CTW-1:0] cnt, cnt_n;

  logic           sel_ok;
  cmd_t           cmd;
  cmd_t           dir_cmd;
  logic [WIDTH-1:0] cur;
  logic [WIDTH:0] cur_x;
  logic [WIDTH:0] up_x;
  logic [WIDTH:0] dn_x;
  logic [WIDTH:0] nv_x;
  logic           do_step;
  logic           do_rst;
  logic           we;
  logic           chg;
  logic           chg_q;

  assign sel_ok = (int'(ch_sel) < CHANNELS);

  // Out-of-range selects decode to NONE, which also aborts a hold
  always_comb begin
    cmd = C_NONE;
    unique case (1'b1)
      !sel_ok:
        cmd = C_NONE;
      sel_ok && speed_rst:
        cmd = C_RST;
      sel_ok && !speed_rst && speed_up && !speed_down:
        cmd = C_UP;
      sel_ok && !speed_rst && !speed_up && speed_down:
        cmd = C_DN;
      default:
        cmd = C_NONE;
    endcase
  end

  always_comb begin
    cur = '0;
    if (sel_ok) cur = vals[ch_sel];
  end

  assign cur_x = {1'b0, cur};

  assign up_x = (cur_x < MIN_X + STEP_X) ?
                MIN_X : cur_x - STEP_X;
  assign dn_x = (cur_x + STEP_X > MAX_X) ?
                MAX_X : cur_x + STEP_X;

  assign dir_cmd = dir ? C_DN : C_UP;

  always_comb begin
    state_n = state;
    dir_n   = dir;
    lch_n   = lch;
    cnt_n   = cnt;
    do_step = 1'b0;
    do_rst  = 1'b0;
    if (cmd == C_RST) begin
      do_rst  = 1'b1;
      state_n = S_IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (cmd == C_UP || cmd == C_DN) begin
            do_step = 1'b1;
            dir_n   = (cmd == C_DN);
            lch_n   = ch_sel;
            cnt_n   = '0;
            state_n = S_HOLD;
          end
        end
        S_HOLD: begin
          if (cmd != dir_cmd || ch_sel != lch) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else if (cnt == HOLD_END) begin
            do_step = 1'b1;
            cnt_n   = '0;
            state_n = S_REPEAT;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        S_REPEAT: begin
          if (cmd != dir_cmd || ch_sel != lch) begin
            state_n = S_IDLE;
            cnt_n   = '0;
          end else if (cnt == REP_END) begin
            do_step = 1'b1;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = S_IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  always_comb begin
    nv_x = cur_x;
    if (do_rst)
      nv_x = DEF_X;
    else if (do_step)
      nv_x = (cmd == C_DN) ? dn_x : up_x;
  end

  assign we  = do_rst | do_step;
  assign chg = we && (nv_x != cur_x);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      dir   <= 1'b0;
      lch   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      dir   <= dir_n;
      lch   <= lch_n;
      cnt   <= cnt_n;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < CHANNELS; i++)
        vals[i] <= DEF_V;
    end else begin
      for (int i = 0; i < CHANNELS; i++)
        if (we && CW'(i) == ch_sel)
          vals[i] <= nv_x[WIDTH-1:0];
    end
  end

  // Change is flagged on the update edge, pulse shows a cycle later
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chg_q      <= 1'b0;
      step_pulse <= 1'b0;
    end else begin
      chg_q      <= chg;
      step_pulse <= chg_q;
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_out
    assign count_out[g*WIDTH +: WIDTH] = vals[g];
  end

  assign at_min = sel_ok && (cur == MIN_V);
  assign at_max = sel_ok && (cur == MAX_V);

endmodule

// File: doc/speed_ctrl_multi.md
# speed_ctrl_multi

Parametrised, multi-channel successor to the jukebox speed controller. It holds one playback-period value per channel and steps the selected channel down (faster) or up (slower) from the front-panel speed buttons. Steps saturate at programmable bounds, and a held button auto-repeats. Each `count_out` slice feeds the matching channel's tone/sample clock divider.

## Interface
Parameters:
- `WIDTH`, 32, bit width of each period value
- `CHANNELS`, 2, number of independent period registers (≥1)
- `DEFAULT`, 1227, reset/restore value; MIN_VAL ≤ DEFAULT ≤ MAX_VAL
- `STEP`, 4, increment/decrement per step (≥1)
- `MIN_VAL`, 256, lower saturation bound
- `MAX_VAL`, 4096, upper saturation bound (< 2^WIDTH)
- `HOLD_CYCLES`, 12_500_000, cycles from first step to first auto-repeat (≥1)
- `REPEAT_CYCLES`, 2_500_000, cycles between auto-repeat steps (≥1)

Ports:
- `clk`  in  1  single clock
- `rst_n`  in  1  asynchronous, active-low reset
- `speed_up`  in  1  level; subtract STEP (shorter period); synchronous to clk
- `speed_down`  in  1  level; add STEP (longer period)
- `speed_rst`  in  1  level; restore selected channel to DEFAULT
- `ch_sel`  in  CW = max(1, $clog2(CHANNELS))  target channel
- `count_out`  out  CHANNELS*WIDTH  channel i at bits [i*WIDTH +: WIDTH]
- `at_min`  out  1  selected channel == MIN_VAL (combinational)
- `at_max`  out  1  selected channel == MAX_VAL (combinational)
- `step_pulse`  out  1  one-cycle pulse, registered, when any channel value changed on the previous edge

## Operation
- Command decode, in priority order:
  - `speed_rst` = 1 → RST.
  - Otherwise up-only → UP.
  - Otherwise down-only → DN.
  - Otherwise (neither, or both) → NONE.
- `ch_sel` ≥ CHANNELS: treated as NONE. `at_min` and `at_max` = 0.
- RST: selected channel ← DEFAULT; FSM → IDLE; counter ← 0. The FSM stays in IDLE while RST persists.
- Step arithmetic is done in WIDTH+1 bits, so there is no wrap:
  - UP: new = (v < MIN_VAL + STEP) ? MIN_VAL : v − STEP.
  - DN: new = (v + STEP > MAX_VAL) ? MAX_VAL : v + STEP.
  - Values already outside the bounds are clamped on the next step.
- Auto-repeat FSM. State holds `dir` (UP/DN), the latched channel `lch`, and a repeat counter.
  - IDLE:
    - UP/DN → apply one step to `ch_sel`; latch `dir` and `lch`; counter ← 0; → HOLD.
    - NONE → stay.
  - HOLD:
    - Command ≠ `dir` or `ch_sel` ≠ `lch` → IDLE, no step that edge.
    - Counter == HOLD_CYCLES−1 → step; counter ← 0; → REPEAT.
    - Otherwise counter++.
  - REPEAT: same abort rule as HOLD. Counter == REPEAT_CYCLES−1 → step; counter ← 0. Otherwise counter++.
- After an abort, IDLE acts on the level present on the following edge. Example: release `speed_down` while `speed_up` stays held → UP step one cycle after the abort.
- A saturated step (new == v) still advances the FSM but does not raise `step_pulse`. The same applies to RST when the value is already DEFAULT.
- Only the targeted channel ever changes; all other channels hold their value.

## Timing
- Reset (`rst_n` low, asynchronous): every channel = DEFAULT, FSM = IDLE, counter = 0, `step_pulse` = 0, `dir`/`lch` = 0.
- Reset release: synchronous de-assertion is assumed upstream.
- Latency: a command sampled at edge k updates `count_out` at edge k. `step_pulse` is high during the cycle after edge k+1.
- Held button: steps occur at edges k, k+HOLD_CYCLES, then every REPEAT_CYCLES edges.
- `rst_n` asserted mid-hold: immediate return to the reset state. No step is applied on release unless a command is present.
- `speed_rst` mid-hold: aborts the FSM on the same edge that restores DEFAULT.

## Test plan
Bench parameters: WIDTH=16, CHANNELS=2, DEFAULT=1227, STEP=4, MIN_VAL=1200, MAX_VAL=1240, HOLD_CYCLES=8, REPEAT_CYCLES=3.
- Reset: assert `rst_n`=0 mid-cycle → both channels 1227 immediately; `step_pulse`=0, `at_min`=`at_max`=0.
- `ch_sel`=0, `speed_up` high for one cycle → ch0 = 1223 after that edge; ch1 = 1227; `step_pulse` high exactly one cycle.
- `ch_sel`=1, `speed_down` held 20 edges → ch1 steps at edges 0, 8, 11, 14, 17, giving 1231, 1235, 1239, 1240, 1240. `step_pulse` fires 4 times; `at_max`=1 from the 4th step on.
- `speed_up`+`speed_down` both held → no change; drop `speed_down` → one UP step (−4) on the next edge, then the HOLD timing restarts.
- Hold `speed_up` on ch0 for 10 edges, then pulse `speed_rst` for one cycle → ch0 = 1227 on the rst edge. With up still held, ch0 = 1223 one edge after rst drops.
- Hold `speed_up`, change `ch_sel` 0→1 at edge 5 → no step at edge 5. ch1 steps at edge 6; ch0 stays at its value after the edge-0 step.
